// File: rtl/target_pattern_gen_pkg.sv
// Shared types for the target pattern generator: sequence-mode encoding.
package target_pattern_pkg;

   localparam int MODE_W = 2;

   typedef enum logic [MODE_W-1:0] {
      MODE_UP   = 2'd0,
      MODE_DOWN = 2'd1,
      MODE_LFSR = 2'd2,
      MODE_HOLD = 2'd3
   } mode_t;

endpackage

// File: rtl/target_pattern_gen_if.sv
// Output stream of the pattern generator: valid/ready beat plus wrap marker.
interface target_pattern_gen_if #(
   parameter int WIDTH    = 12,
   parameter int CHANNELS = 4
);
   logic                      out_valid;
   logic                      out_ready;
   logic [CHANNELS*WIDTH-1:0] out_data;
   logic                      wrap;

   modport master (output out_valid, output out_data, output wrap, input out_ready);
   modport slave  (input out_valid, input out_data, input wrap, output out_ready);
endinterface

// File: rtl/target_pattern_gen_lfsr.sv
// Combinational Galois LFSR step: shift right, fold taps in when bit 0 falls out.
module pattern_lfsr #(
   parameter int               WIDTH     = 12,
   parameter logic [WIDTH-1:0] LFSR_TAPS = 12'hE08
) (
   input  logic [WIDTH-1:0] cur,
   output logic [WIDTH-1:0] nxt
);

   // Next state; an all-zero state maps to itself by construction.
   always_comb begin
      nxt = cur >> 1;
      if (cur[0]) begin
         nxt = (cur >> 1) ^ LFSR_TAPS;
      end else begin
         nxt = cur >> 1;
      end
   end

endmodule

// File: rtl/target_pattern_gen.sv
// Multi-channel test-pattern source with valid/ready output.
// Optional build macro TARGET_PATTERN_GEN_ERR_INJECT_EN adds an err_inject
// input that flips bit 0 of channel 0 on the beat registered by a fire or load.
module target_pattern_gen
   import target_pattern_pkg::*;
#(
   parameter int               WIDTH     = 12,
   parameter int               CHANNELS  = 4,
   parameter int               STRIDE    = 1,
   parameter logic [WIDTH-1:0] LFSR_TAPS = 12'hE08,
   parameter logic [WIDTH-1:0] LFSR_INIT = {{(WIDTH-1){1'b0}}, 1'b1}
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              enable,
   input  logic [MODE_W-1:0] mode,
   input  logic [WIDTH-1:0]  limit,
   input  logic              load,
`ifdef TARGET_PATTERN_GEN_ERR_INJECT_EN
   input  logic              err_inject,
`endif
   target_pattern_gen_if.master out_if
);

   localparam int DW = CHANNELS * WIDTH;

   logic [WIDTH-1:0] base_r;
   logic             valid_r;
   logic [DW-1:0]    data_r;
   logic             wrap_r;

   mode_t            mode_s;
   logic [WIDTH-1:0] start_s;
   logic [WIDTH-1:0] next_s;
   logic [WIDTH-1:0] lfsr_next_s;
   logic             wrap_next_s;
   logic             fire_s;
   logic [DW-1:0]    inj_mask_s;

   // Channel k carries base + k*STRIDE, truncated to the channel width.
   function automatic logic [DW-1:0] image_f(input logic [WIDTH-1:0] v);
      logic [DW-1:0] img;
      img = '0;
      for (int k = 0; k < CHANNELS; k++) begin
         img[k*WIDTH +: WIDTH] = v + WIDTH'(k * STRIDE);
      end
      return img;
   endfunction

   assign mode_s = mode_t'(mode);
   assign fire_s = valid_r & out_if.out_ready;

`ifdef TARGET_PATTERN_GEN_ERR_INJECT_EN
   assign inj_mask_s = {{(DW-1){1'b0}}, err_inject};
`else
   assign inj_mask_s = '0;
`endif

   pattern_lfsr #(
      .WIDTH     (WIDTH),
      .LFSR_TAPS (LFSR_TAPS)
   ) u_lfsr (
      .cur (base_r),
      .nxt (lfsr_next_s)
   );

   // Sequence start value for the currently selected mode.
   always_comb begin
      start_s = base_r;
      case (mode_s)
         MODE_UP:   start_s = {WIDTH{1'b0}};
         MODE_DOWN: start_s = limit;
         MODE_LFSR: start_s = LFSR_INIT;
         MODE_HOLD: start_s = base_r;
         default:   start_s = base_r;
      endcase
   end

   // Successor of base; DOWN snaps to limit if base sits above a lowered limit.
   always_comb begin
      next_s = base_r;
      case (mode_s)
         MODE_UP: begin
            if (base_r >= limit) begin
               next_s = {WIDTH{1'b0}};
            end else begin
               next_s = base_r + {{(WIDTH-1){1'b0}}, 1'b1};
            end
         end
         MODE_DOWN: begin
            if (base_r == {WIDTH{1'b0}}) begin
               next_s = limit;
            end else if (base_r > limit) begin
               next_s = limit;
            end else begin
               next_s = base_r - {{(WIDTH-1){1'b0}}, 1'b1};
            end
         end
         MODE_LFSR: next_s = lfsr_next_s;
         MODE_HOLD: next_s = base_r;
         default:   next_s = base_r;
      endcase
   end

   // A fire wraps when it lands back on the start value; HOLD never wraps.
   always_comb begin
      wrap_next_s = 1'b0;
      if (mode_s != MODE_HOLD) begin
         wrap_next_s = (next_s == start_s);
      end else begin
         wrap_next_s = 1'b0;
      end
   end

   // Base and output registers: reset > load > fire > idle fill/hold.
   always_ff @(posedge clk) begin
      if (reset) begin
         base_r  <= (mode_s == MODE_LFSR) ? LFSR_INIT : {WIDTH{1'b0}};
         valid_r <= 1'b0;
         data_r  <= {DW{1'b0}};
         wrap_r  <= 1'b0;
      end else if (load) begin
         base_r  <= start_s;
         data_r  <= image_f(start_s) ^ inj_mask_s;
         valid_r <= enable;
         wrap_r  <= 1'b0;
      end else if (fire_s) begin
         base_r  <= next_s;
         data_r  <= image_f(next_s) ^ inj_mask_s;
         valid_r <= enable;
         wrap_r  <= wrap_next_s;
      end else begin
         wrap_r <= 1'b0;
         if (!valid_r && enable) begin
            valid_r <= 1'b1;
            data_r  <= image_f(base_r);
         end else begin
            valid_r <= valid_r;
            data_r  <= data_r;
         end
      end
   end

   assign out_if.out_valid = valid_r;
   assign out_if.out_data  = data_r;
   assign out_if.wrap      = wrap_r;

endmodule

// File: tb/tb_target_pattern_gen.sv
// Self-checking bench for target_pattern_gen: directed scenarios plus random
// stimulus against a cycle-level reference model of the sequence rules.
module tb_target_pattern_gen;

   localparam int W      = 12;
   localparam int CH     = 4;
   localparam int STRIDE = 1;
   localparam int TAPS   = 'hE08;
   localparam int MODV   = 4096;

   logic        clk = 1'b0;
   logic        reset;
   logic        enable;
   logic [1:0]  mode;
   logic [11:0] limit;
   logic        load;
`ifdef TARGET_PATTERN_GEN_ERR_INJECT_EN
   logic        err_inject;
`endif

   target_pattern_gen_if #(.WIDTH(W), .CHANNELS(CH)) bus ();

   target_pattern_gen dut (
      .clk        (clk),
      .reset      (reset),
      .enable     (enable),
      .mode       (mode),
      .limit      (limit),
      .load       (load),
`ifdef TARGET_PATTERN_GEN_ERR_INJECT_EN
      .err_inject (err_inject),
`endif
      .out_if     (bus)
   );

   always #5 clk = ~clk;

   int check_cnt = 0;
   int pass_cnt  = 0;

   // reference model state
   int          m_base  = 0;
   logic        m_valid = 1'b0;
   logic [47:0] m_data  = '0;
   logic        m_wrap  = 1'b0;

   function automatic logic [47:0] tb_image(int v);
      logic [47:0] r;
      r = '0;
      for (int k = 0; k < CH; k++) r[k*W +: W] = W'((v + k*STRIDE) % MODV);
      return r;
   endfunction

   function automatic int seq_start(int md, int lim, int b);
      case (md)
         0: return 0;
         1: return lim;
         2: return 1;
         default: return b;
      endcase
   endfunction

   function automatic int seq_next(int md, int lim, int b);
      case (md)
         0: return (b >= lim) ? 0 : b + 1;
         1: return (b == 0) ? lim : ((b > lim) ? lim : b - 1);
         2: return (b >> 1) ^ (((b & 1) != 0) ? TAPS : 0);
         default: return b;
      endcase
   endfunction

   function automatic logic [47:0] inj_mask();
`ifdef TARGET_PATTERN_GEN_ERR_INJECT_EN
      return {47'd0, err_inject};
`else
      return 48'd0;
`endif
   endfunction

   // advance the model by one clock using the inputs currently driven
   task automatic model_step();
      int md, lim, s, n;
      md  = int'(mode);
      lim = int'(limit);
      if (reset) begin
         m_base = (md == 2) ? 1 : 0;
         m_valid = 1'b0; m_data = '0; m_wrap = 1'b0;
      end else if (load) begin
         s = seq_start(md, lim, m_base);
         m_base = s; m_data = tb_image(s) ^ inj_mask(); m_valid = enable; m_wrap = 1'b0;
      end else if (m_valid && bus.out_ready) begin
         s = seq_start(md, lim, m_base);
         n = seq_next(md, lim, m_base);
         m_wrap = (md != 3) && (n == s);
         m_base = n; m_data = tb_image(n) ^ inj_mask(); m_valid = enable;
      end else begin
         m_wrap = 1'b0;
         if (!m_valid && enable) begin
            m_valid = 1'b1;
            m_data  = tb_image(m_base);
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      @(negedge clk);
   endtask

   task automatic test_reset();
      reset = 1'b1; enable = 1'b0; mode = 2'd0; limit = 12'd3; load = 1'b0;
      bus.out_ready = 1'b0;
      tick();
      reset = 1'b0;
      check_cnt++;
      if (bus.out_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", bus.out_valid); else pass_cnt++;
      check_cnt++;
      if (bus.out_data !== 48'd0) $display("FAIL reset_data: got %h want 0", bus.out_data); else pass_cnt++;
      check_cnt++;
      if (bus.wrap !== 1'b0) $display("FAIL reset_wrap: got %b want 0", bus.wrap); else pass_cnt++;
   endtask

   task automatic test_up_wrap();
      int exp_ch0 [5] = '{0, 1, 2, 3, 0};
      int exp_wr  [5] = '{0, 0, 0, 0, 1};
      reset = 1'b1; enable = 1'b1; mode = 2'd0; limit = 12'd3; bus.out_ready = 1'b1;
      tick();
      reset = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         check_cnt++;
         if (bus.out_data[11:0] !== 12'(exp_ch0[i]))
            $display("FAIL up_ch0 beat %0d: got %0d want %0d", i, bus.out_data[11:0], exp_ch0[i]);
         else pass_cnt++;
         check_cnt++;
         if (bus.out_data[23:12] !== 12'(exp_ch0[i] + 1))
            $display("FAIL up_ch1 beat %0d: got %0d want %0d", i, bus.out_data[23:12], exp_ch0[i] + 1);
         else pass_cnt++;
         check_cnt++;
         if ({bus.out_valid, bus.wrap} !== {1'b1, 1'(exp_wr[i])})
            $display("FAIL up_valid_wrap beat %0d: got %b%b want 1%0d", i, bus.out_valid, bus.wrap, exp_wr[i]);
         else pass_cnt++;
      end
   endtask

   task automatic test_down();
      int exp_ch0 [4] = '{2, 1, 0, 2};
      int exp_wr  [4] = '{0, 0, 0, 1};
      mode = 2'd1; limit = 12'd2; load = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         load = 1'b0;
         check_cnt++;
         if (bus.out_data[11:0] !== 12'(exp_ch0[i]) || bus.wrap !== 1'(exp_wr[i]))
            $display("FAIL down beat %0d: got ch0=%0d wrap=%b want ch0=%0d wrap=%0d",
                     i, bus.out_data[11:0], bus.wrap, exp_ch0[i], exp_wr[i]);
         else pass_cnt++;
      end
   endtask

   task automatic test_stall();
      mode = 2'd0; limit = 12'd100; load = 1'b1; bus.out_ready = 1'b1; enable = 1'b1;
      tick();
      load = 1'b0;
      for (int i = 0; i < 5; i++) tick();
      check_cnt++;
      if (bus.out_data[11:0] !== 12'd5) $display("FAIL stall_pre: got %0d want 5", bus.out_data[11:0]); else pass_cnt++;
      bus.out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         enable = (i != 1);
         tick();
         check_cnt++;
         if (bus.out_valid !== 1'b1 || bus.out_data[11:0] !== 12'd5 || bus.out_data !== m_data)
            $display("FAIL stall_hold cyc %0d: got valid=%b data=%h want valid=1 data=%h",
                     i, bus.out_valid, bus.out_data, m_data);
         else pass_cnt++;
      end
      enable = 1'b1; bus.out_ready = 1'b1;
      for (int i = 0; i < 2; i++) begin
         tick();
         check_cnt++;
         if (bus.out_data[11:0] !== 12'(6 + i))
            $display("FAIL stall_resume %0d: got %0d want %0d", i, bus.out_data[11:0], 6 + i);
         else pass_cnt++;
      end
   endtask

   task automatic test_load_priority();
      mode = 2'd0; limit = 12'd100; load = 1'b1; bus.out_ready = 1'b1; enable = 1'b1;
      tick();
      load = 1'b0;
      for (int i = 0; i < 7; i++) tick();
      check_cnt++;
      if (bus.out_data[11:0] !== 12'd7) $display("FAIL load_pre: got %0d want 7", bus.out_data[11:0]); else pass_cnt++;
      load = 1'b1;
      tick();
      load = 1'b0;
      check_cnt++;
      if (bus.out_data[11:0] !== 12'd0 || bus.wrap !== 1'b0 || bus.out_valid !== 1'b1)
         $display("FAIL load_over_fire: got ch0=%0d wrap=%b valid=%b want 0 0 1",
                  bus.out_data[11:0], bus.wrap, bus.out_valid);
      else pass_cnt++;
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check_cnt++;
      if (bus.out_valid !== 1'b0 || bus.out_data !== 48'd0)
         $display("FAIL midstream_reset: got valid=%b data=%h want 0 0", bus.out_valid, bus.out_data);
      else pass_cnt++;
   endtask

   task automatic test_lfsr();
      bit seen [4096];
      int repeats = 0;
      int wraps = 0;
      int v;
      mode = 2'd2; load = 1'b1; enable = 1'b1; bus.out_ready = 1'b1;
      tick();
      load = 1'b0;
      check_cnt++;
      if (bus.out_data[11:0] !== 12'd1) $display("FAIL lfsr_start: got %0d want 1", bus.out_data[11:0]); else pass_cnt++;
      foreach (seen[i]) seen[i] = 1'b0;
      seen[1] = 1'b1;
      for (int i = 0; i < 4095; i++) begin
         tick();
         v = int'(bus.out_data[11:0]);
         check_cnt++;
         if (bus.out_data !== m_data || bus.wrap !== m_wrap)
            $display("FAIL lfsr_beat %0d: got data=%h wrap=%b want data=%h wrap=%b",
                     i, bus.out_data, bus.wrap, m_data, m_wrap);
         else pass_cnt++;
         if (bus.wrap === 1'b1) wraps++;
         if (i < 4094) begin
            if (seen[v]) repeats++;
            seen[v] = 1'b1;
         end
      end
      check_cnt++;
      if (repeats != 0) $display("FAIL lfsr_no_repeat: got %0d repeats want 0", repeats); else pass_cnt++;
      check_cnt++;
      if (wraps != 1 || v != 1 || bus.wrap !== 1'b1)
         $display("FAIL lfsr_wrap: got wraps=%0d last=%0d wrap=%b want 1 1 1", wraps, v, bus.wrap);
      else pass_cnt++;
   endtask

`ifdef TARGET_PATTERN_GEN_ERR_INJECT_EN
   task automatic test_err_inject();
      mode = 2'd0; limit = 12'd100; load = 1'b1; bus.out_ready = 1'b1; enable = 1'b1;
      tick();
      load = 1'b0;
      for (int i = 0; i < 3; i++) tick();
      err_inject = 1'b1;
      tick();
      err_inject = 1'b0;
      check_cnt++;
      if (bus.out_data[11:0] !== 12'd5 || bus.out_data[23:12] !== 12'd5)
         $display("FAIL err_inject_beat: got ch0=%0d ch1=%0d want 5 5", bus.out_data[11:0], bus.out_data[23:12]);
      else pass_cnt++;
      tick();
      check_cnt++;
      if (bus.out_data !== tb_image(5))
         $display("FAIL err_inject_clean: got %h want %h", bus.out_data, tb_image(5));
      else pass_cnt++;
   endtask
`endif

   task automatic test_random();
      for (int i = 0; i < 3000; i++) begin
         reset         = ($urandom_range(0, 199) == 0);
         load          = ($urandom_range(0, 15) == 0);
         enable        = ($urandom_range(0, 7) != 0);
         bus.out_ready = ($urandom_range(0, 2) != 0);
         if ($urandom_range(0, 31) == 0) mode = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 31) == 0)
            limit = ($urandom_range(0, 1) == 0) ? 12'($urandom_range(0, 15)) : 12'($urandom_range(0, 4095));
`ifdef TARGET_PATTERN_GEN_ERR_INJECT_EN
         err_inject = ($urandom_range(0, 7) == 0);
`endif
         tick();
         check_cnt++;
         if (bus.out_valid !== m_valid || bus.out_data !== m_data || bus.wrap !== m_wrap)
            $display("FAIL random cyc %0d: got v=%b d=%h w=%b want v=%b d=%h w=%b",
                     i, bus.out_valid, bus.out_data, bus.wrap, m_valid, m_data, m_wrap);
         else pass_cnt++;
      end
`ifdef TARGET_PATTERN_GEN_ERR_INJECT_EN
      err_inject = 1'b0;
`endif
   endtask

   initial begin
`ifdef TARGET_PATTERN_GEN_ERR_INJECT_EN
      err_inject = 1'b0;
`endif
      @(negedge clk);
      test_reset();
      test_up_wrap();
      test_down();
      test_stall();
      test_load_priority();
      test_lfsr();
`ifdef TARGET_PATTERN_GEN_ERR_INJECT_EN
      test_err_inject();
`endif
      test_random();
      $display("%0d/%0d checks passed", pass_cnt, check_cnt);
      $finish;
   end

endmodule
